// File: rtl/rr_priority_arbiter_pkg.sv
// Shared constants and types for the N-way round-robin / fixed-priority arbiter.
package arb_pkg;

  // Arbitration policy selectors for the MODE parameter.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // IDLE: no grant outstanding. GRANT: a registered grant is being presented.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_priority_arbiter_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );

endinterface : rr_priority_arbiter_if

// File: rtl/rr_priority_arbiter_prio_enc_n.sv
// Combinational N-input priority encoder: the highest set bit wins.
module prio_enc_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan upward so the last (highest) set bit overwrites earlier hits.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise req==0
    // leaves idx unassigned on that path and a latch is inferred.
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule : prio_enc_n

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with registered one-hot grant, fixed-priority or round-robin
// selection, optional grant locking and a starvation guard on locked grants.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int IDX_W    = $clog2(N),
  parameter int MODE     = ARB_RR,
  parameter int LOCK     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_priority_arbiter_if.slave bus
);

  // Hold counter is at least one bit wide even when the guard is disabled.
  localparam int                HC_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0]   HOLD_LIM = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]    N_EXT    = (IDX_W + 1)'(N);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;

  logic             holder_req;
  logic             others_req;
  logic             guard;
  logic             hold;
  logic [N-1:0]     arb_req;
  logic [N-1:0]     rot_rev;
  logic [IDX_W:0]   rot_sum;
  logic [N-1:0]     enc_in;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W:0]   un_sum;
  logic [IDX_W-1:0] win;

  logic [N-1:0]     nxt_grant;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_valid;
  logic [HC_W-1:0]  nxt_hold;
  logic [IDX_W-1:0] nxt_ptr;

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

  // A locked holder keeps the grant unless it drops req or the guard fires;
  // the guard masks the holder out so a waiting requester must win.
  assign holder_req = valid_q && bus.req[idx_q];
  assign others_req = |(bus.req & ~grant_q);
  assign guard      = (LOCK != 0) && (MAX_HOLD > 0) && (state == ARB_GRANT) &&
                      holder_req && others_req && (hold_cnt >= HOLD_LIM);
  assign hold       = (LOCK != 0) && (state == ARB_GRANT) && holder_req && !guard;
  assign arb_req    = guard ? (bus.req & ~grant_q) : bus.req;

  // Rotate requests so ptr lands at bit 0, then bit-reverse so the
  // highest-wins encoder picks the first request at or above ptr.
  always_comb begin
    rot_rev = '0;
    rot_sum = '0;
    for (int i = 0; i < N; i++) begin
      rot_sum = {1'b0, IDX_W'(i)} + {1'b0, ptr};
      if (rot_sum >= N_EXT) rot_sum = rot_sum - N_EXT;
      rot_rev[N-1-i] = arb_req[rot_sum[IDX_W-1:0]];
    end
  end

  assign enc_in = (MODE == ARB_RR) ? rot_rev : arb_req;

  prio_enc_n #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .req (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Undo the reversal and rotation to recover the absolute winner index.
  always_comb begin
    un_sum = '0;
    win    = enc_idx;
    if (MODE == ARB_RR) begin
      un_sum = {1'b0, LAST_IDX - enc_idx} + {1'b0, ptr};
      if (un_sum >= N_EXT) un_sum = un_sum - N_EXT;
      win = un_sum[IDX_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= ARB_IDLE;
    else        state <= next_state;
  end

  // Next-state: stay in GRANT while holding or while any request can be served.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE:  if (enc_any) next_state = ARB_GRANT;
      ARB_GRANT: if (!hold && !enc_any) next_state = ARB_IDLE;
      default:   next_state = ARB_IDLE;
    endcase
  end

  // Output decode: hold the current grant, load a new winner, or clear.
  always_comb begin
    nxt_grant = '0;
    nxt_idx   = '0;
    nxt_valid = 1'b0;
    nxt_hold  = '0;
    nxt_ptr   = ptr;
    if (hold) begin
      nxt_grant = grant_q;
      nxt_idx   = idx_q;
      nxt_valid = valid_q;
      nxt_hold  = (hold_cnt != '1) ? hold_cnt + HC_W'(1) : hold_cnt;
    end else if (enc_any) begin
      nxt_grant[win] = 1'b1;
      nxt_idx        = win;
      nxt_valid      = 1'b1;
      if (MODE == ARB_RR) nxt_ptr = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
    end
  end

  // Grant, pointer and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      grant_q  <= nxt_grant;
      idx_q    <= nxt_idx;
      valid_q  <= nxt_valid;
      hold_cnt <= nxt_hold;
      ptr      <= nxt_ptr;
    end
  end

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: directed stimulus pushes hand-computed grants into a
// queue, a negedge monitor pops and compares against four arbiter configs.
module tb_rr_priority_arbiter;
  import arb_pkg::*;

  localparam int D_FIX = 0;  // MODE=0, LOCK=1
  localparam int D_RR0 = 1;  // MODE=1, LOCK=0
  localparam int D_RR1 = 2;  // MODE=1, LOCK=1, unlimited hold
  localparam int D_RRH = 3;  // MODE=1, LOCK=1, MAX_HOLD=4

  typedef struct {
    int unsigned cyc;
    int          dut;
    int          tid;
    logic [7:0]  grant;
    logic [2:0]  idx;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  rr_priority_arbiter_if #(.N(8)) if_fix ();
  rr_priority_arbiter_if #(.N(8)) if_rr0 ();
  rr_priority_arbiter_if #(.N(8)) if_rr1 ();
  rr_priority_arbiter_if #(.N(8)) if_rrh ();

  rr_priority_arbiter #(.N(8), .MODE(ARB_FIXED), .LOCK(1), .MAX_HOLD(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(if_fix.slave));
  rr_priority_arbiter #(.N(8), .MODE(ARB_RR), .LOCK(0), .MAX_HOLD(0)) u_rr0 (
    .clk(clk), .rst_n(rst_n), .bus(if_rr0.slave));
  rr_priority_arbiter #(.N(8), .MODE(ARB_RR), .LOCK(1), .MAX_HOLD(0)) u_rr1 (
    .clk(clk), .rst_n(rst_n), .bus(if_rr1.slave));
  rr_priority_arbiter #(.N(8), .MODE(ARB_RR), .LOCK(1), .MAX_HOLD(4)) u_rrh (
    .clk(clk), .rst_n(rst_n), .bus(if_rrh.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] sample(input int dut);
    case (dut)
      D_FIX:   return {if_fix.grant, if_fix.grant_idx, if_fix.grant_valid};
      D_RR0:   return {if_rr0.grant, if_rr0.grant_idx, if_rr0.grant_valid};
      D_RR1:   return {if_rr1.grant, if_rr1.grant_idx, if_rr1.grant_valid};
      default: return {if_rrh.grant, if_rrh.grant_idx, if_rrh.grant_valid};
    endcase
  endfunction

  task automatic set_req(input int dut, input logic [7:0] r);
    case (dut)
      D_FIX:   if_fix.req = r;
      D_RR0:   if_rr0.req = r;
      D_RR1:   if_rr1.req = r;
      default: if_rrh.req = r;
    endcase
  endtask

  // Expected outputs after the next rising edge.
  task automatic expect_next(input int dut, input int idx, input bit valid, input int tid);
    exp_t e;
    e.cyc   = cyc + 1;
    e.dut   = dut;
    e.tid   = tid;
    e.idx   = valid ? 3'(idx) : 3'd0;
    e.valid = valid;
    e.grant = valid ? (8'd1 << idx) : 8'd0;
    sb_q.push_back(e);
  endtask

  // Drive req just after an edge; it is sampled at the following edge.
  task automatic cycle(input int dut, input logic [7:0] r, input int idx, input bit valid,
                       input int tid);
    @(posedge clk);
    #1;
    set_req(dut, r);
    expect_next(dut, idx, valid, tid);
  endtask

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      check($sformatf("t%0d_dut%0d_cyc%0d", mon_e.tid, mon_e.dut, mon_e.cyc),
            32'(sample(mon_e.dut)), 32'({mon_e.grant, mon_e.idx, mon_e.valid}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_seq[10]  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int rr_wrap[3]  = '{4, 7, 4};
    int hold_seq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    rst_n = 1'b0;
    set_req(D_FIX, 8'hFF);
    set_req(D_RR0, 8'h00);
    set_req(D_RR1, 8'h00);
    set_req(D_RRH, 8'h00);

    // Test 1: reset with all requests high, then fixed mode picks index 7.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) check($sformatf("reset_dut%0d", d), 32'(sample(d)), 32'd0);
    rst_n = 1'b1;
    expect_next(D_FIX, 7, 1'b1, 1);
    expect_next(D_RR0, 0, 1'b0, 1);
    expect_next(D_RR1, 0, 1'b0, 1);
    expect_next(D_RRH, 0, 1'b0, 1);
    cycle(D_FIX, 8'hFF, 7, 1'b1, 1);

    // Test 2: fixed priority on a sparse vector, then release to IDLE.
    cycle(D_FIX, 8'b0000_1101, 3, 1'b1, 2);
    cycle(D_FIX, 8'b0000_1101, 3, 1'b1, 2);
    cycle(D_FIX, 8'b0000_0101, 2, 1'b1, 2);
    cycle(D_FIX, 8'b0000_0000, 0, 1'b0, 2);
    drain();

    // Test 3: round robin without lock walks every index and wraps.
    foreach (rr_seq[i]) cycle(D_RR0, 8'hFF, rr_seq[i], 1'b1, 3);
    cycle(D_RR0, 8'h00, 0, 1'b0, 3);
    foreach (rr_wrap[i]) cycle(D_RR0, 8'b1001_0000, rr_wrap[i], 1'b1, 3);
    cycle(D_RR0, 8'h00, 0, 1'b0, 3);
    drain();

    // Test 4: locked grant held until holder drops, then back-to-back handover.
    cycle(D_RR1, 8'b0010_0010, 1, 1'b1, 4);
    repeat (3) cycle(D_RR1, 8'b0010_0010, 1, 1'b1, 4);
    cycle(D_RR1, 8'b0010_0000, 5, 1'b1, 4);
    cycle(D_RR1, 8'b0000_1001, 0, 1'b1, 4);
    cycle(D_RR1, 8'b0000_1000, 3, 1'b1, 4);
    drain();

    // Test 6: async reset mid-grant, first grant after reset uses ptr=0.
    set_req(D_RR1, 8'b1000_0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_grant", 32'(sample(D_RR1)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_next(D_RR1, 1, 1'b1, 6);
    cycle(D_RR1, 8'h00, 0, 1'b0, 6);
    cycle(D_RR1, 8'h00, 0, 1'b0, 6);
    drain();

    // Test 5: starvation guard alternates every 4 cycles, saturates when alone.
    cycle(D_RRH, 8'b0000_0011, hold_seq[0], 1'b1, 5);
    for (int i = 1; i < 12; i++) cycle(D_RRH, 8'b0000_0011, hold_seq[i], 1'b1, 5);
    repeat (7) cycle(D_RRH, 8'b0000_0001, 0, 1'b1, 5);
    cycle(D_RRH, 8'b0000_0011, 1, 1'b1, 5);
    cycle(D_RRH, 8'b0000_0000, 0, 1'b0, 5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rr_priority_arbiter
